hpi_access_ctrl: RTL and testbench
==================================

# hpi_access_ctrl

Sequences CY7C67200 host-port (HPI) transactions for the USB OTG path and shares that port between two requesters: requester 0 is the CPU bridge, requester 1 the hardware interrupt/poll engine. It turns one-word read/write requests into a timed chip-select/strobe sequence on the `from_sw_*` side of the HPI I/O interface block, captures read data, and acknowledges each access with a single-cycle pulse. All OTG pin timing derives from this block's outputs. The I/O interface adds one register stage on the pin side.

## Interface
- STROBE_CYCLES, 2: cycles RD/WR strobe held low; legal 1..15.
- RECOVER_CYCLES, 2: cycles CS held high after an access before the next may start; legal 1..15.

- Clk  in  1  system clock
- Reset  in  1  asynchronous, active-high
- req0, req1  in  1  access request; held high until matching ack
- we0, we1  in  1  1 = write, 0 = read; sampled with req
- addr0, addr1  in  2  HPI register select (0 DATA, 1 MAILBOX, 2 ADDRESS, 3 STATUS)
- wdata0, wdata1  in  16  write data
- ack0, ack1  out  1  one-cycle completion pulse
- rdata  out  16  read data, valid with ack, held until next read completes
- busy  out  1  high from grant through last RECOVER cycle
- hpi_address  out  2  to from_sw_address
- hpi_data_out  out  16  to from_sw_data_out
- hpi_data_in  in  16  from from_sw_data_in
- hpi_r, hpi_w, hpi_cs  out  1  to from_sw_r/w/cs, active-low

## Operation
- States: IDLE, SETUP, STROBE, HOLD, RECOVER.
- IDLE: if any req is high, grant one requester. Latch its we/addr/wdata into hpi_address/hpi_data_out and go to SETUP.
- SETUP (1 cycle): hpi_cs=0, hpi_r=hpi_w=1, address and data driven.
- STROBE (STROBE_CYCLES cycles): hpi_cs=0, hpi_r=0 for a read or hpi_w=0 for a write.
- HOLD (1 cycle): strobes high, hpi_cs=0. On a read, rdata <= hpi_data_in at the edge leaving HOLD.
- RECOVER (RECOVER_CYCLES cycles): hpi_cs=1. The granted ack pulses in the first RECOVER cycle. Then go to IDLE.
- hpi_address and hpi_data_out stay stable from SETUP through HOLD and keep their value afterwards.
- A 4-bit down-counter times STROBE and RECOVER. It is loaded with the parameter minus 1 on state entry, and the state advances when the counter is 0.
- A req deasserted mid-access is ignored: the access completes and ack still pulses. Write requests never modify rdata.
- Only one of hpi_r and hpi_w is ever low. Neither is low while hpi_cs is high.

## Timing
- Reset values: hpi_cs=hpi_r=hpi_w=1, hpi_address=0, hpi_data_out=0, rdata=0, ack0=ack1=0, busy=0, state IDLE, round-robin pointer=requester 0.
- Reset asserted mid-access: all strobes and CS return high immediately (asynchronous). No ack is issued for the aborted access.
- req sampled in IDLE at edge k. SETUP occupies cycle k+1, and ack occurs in cycle k+STROBE_CYCLES+3.
- Access period between grants is 3+STROBE_CYCLES+RECOVER_CYCLES cycles, counting the IDLE cycle. The default gives 7.
- Simultaneous req0 and req1 in IDLE are resolved per Configuration. The loser stays pending and is granted at the next IDLE.

## Configuration
- HPI_CTRL_RR_EN defined: round-robin arbitration.
  - The pointer moves to the other requester after each grant.
  - If both are requesting, the requester the pointer selects wins.
  - A single requester is always granted.
- HPI_CTRL_RR_EN undefined: fixed priority, requester 0 always wins. Requester 1 may starve.

## Test plan
- Reset with req0 high: all outputs at reset values, no ack, busy=0 until Reset falls.
- Write, default params:
  - Stimulus: req0, we0=1, addr0=2, wdata0=16'h1234 at edge k.
  - Required: hpi_cs low cycles k+1..k+4, hpi_w low k+2..k+3, hpi_data_out=16'h1234 throughout, ack0 pulses at k+5.
- Read, default params:
  - Stimulus: req1, we1=0, addr1=0, with hpi_data_in=16'hBEEF during HOLD.
  - Required: hpi_r low 2 cycles, ack1 at k+5 with rdata=16'hBEEF, rdata unchanged by a later write.
- Contention:
  - Stimulus: req0 and req1 held continuously for 4 accesses.
  - Required with HPI_CTRL_RR_EN: grants 0,1,0,1, ack spacing 7 cycles. Required without it: grants 0,0,0,0.
- Reset during STROBE of a write: hpi_w and hpi_cs high within the same cycle, no ack, next request after release runs a full sequence.
- Parameter corners:
  - STROBE_CYCLES=1, RECOVER_CYCLES=1: strobe low exactly 1 cycle, access period 5.
  - STROBE_CYCLES=15: strobe low 15 cycles.

Source files
------------

// File: rtl/hpi_access_ctrl.sv
// hpi_access_ctrl: shares the CY7C67200 host port between the CPU bridge (requester 0)
// and the interrupt/poll engine (requester 1), sequencing each one-word access as
// SETUP -> STROBE -> HOLD -> RECOVER on the active-low cs/r/w strobes.
// Optional feature: define HPI_CTRL_RR_EN for round-robin arbitration; the default
// build gives requester 0 fixed priority.
module hpi_access_ctrl #(
    parameter int unsigned STROBE_CYCLES  = 2,
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    input  logic [15:0] hpi_data_in,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold,
        StRecover
    } state_t;

    // Counter reload values: the state advances when the counter reaches zero.
    localparam logic [3:0] strobe_load  = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] recover_load = 4'(RECOVER_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       gnt;        // requester owning the current access
    logic       is_write;   // direction of the current access
    logic       grant_next; // requester that would win in IDLE this cycle

`ifdef HPI_CTRL_RR_EN
    logic       rr_ptr;     // requester favoured when both are requesting
`endif

    // Arbitration between the two requesters, evaluated while idle.
    always_comb begin
        grant_next = 1'b0;
`ifdef HPI_CTRL_RR_EN
        if (req0 && req1) begin
            grant_next = rr_ptr;
        end else begin
            grant_next = req1;
        end
`else
        grant_next = ~req0;
`endif
    end

    // Access sequencer: state, timing counter and all registered pin-side outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= StIdle;
            cnt          <= 4'd0;
            gnt          <= 1'b0;
            is_write     <= 1'b0;
            ack0         <= 1'b0;
            ack1         <= 1'b0;
            rdata        <= 16'h0000;
            busy         <= 1'b0;
            hpi_address  <= 2'd0;
            hpi_data_out <= 16'h0000;
            hpi_r        <= 1'b1;
            hpi_w        <= 1'b1;
            hpi_cs       <= 1'b1;
`ifdef HPI_CTRL_RR_EN
            rr_ptr       <= 1'b0;
`endif
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            case (state)
                StIdle: begin
                    if (req0 || req1) begin
                        gnt          <= grant_next;
                        is_write     <= grant_next ? we1 : we0;
                        hpi_address  <= grant_next ? addr1 : addr0;
                        hpi_data_out <= grant_next ? wdata1 : wdata0;
                        hpi_cs       <= 1'b0;
                        busy         <= 1'b1;
                        state        <= StSetup;
`ifdef HPI_CTRL_RR_EN
                        rr_ptr       <= ~grant_next;
`endif
                    end
                end
                StSetup: begin
                    cnt   <= strobe_load;
                    state <= StStrobe;
                    if (is_write) begin
                        hpi_w <= 1'b0;
                    end else begin
                        hpi_r <= 1'b0;
                    end
                end
                StStrobe: begin
                    if (cnt == 4'd0) begin
                        hpi_r <= 1'b1;
                        hpi_w <= 1'b1;
                        state <= StHold;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StHold: begin
                    hpi_cs <= 1'b1;
                    cnt    <= recover_load;
                    state  <= StRecover;
                    if (!is_write) begin
                        rdata <= hpi_data_in;
                    end
                    if (gnt) begin
                        ack1 <= 1'b1;
                    end else begin
                        ack0 <= 1'b1;
                    end
                end
                StRecover: begin
                    if (cnt == 4'd0) begin
                        busy  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hpi_access_ctrl.sv
// tb_hpi_access_ctrl: three instances (default timing, fastest corner, longest strobe),
// each driven through directed and random accesses and compared cycle by cycle with an
// arithmetic timeline model built from the access timing rules.
module tb_hpi_access_ctrl;

    localparam int S_TAB [3] = '{2, 1, 15};
    localparam int R_TAB [3] = '{2, 1, 2};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0 [3];
    logic        req1 [3];
    logic        we0 [3];
    logic        we1 [3];
    logic [1:0]  addr0 [3];
    logic [1:0]  addr1 [3];
    logic [15:0] wdata0 [3];
    logic [15:0] wdata1 [3];
    logic [15:0] din [3];
    logic        ack0 [3];
    logic        ack1 [3];
    logic        busy [3];
    logic        hr [3];
    logic        hw [3];
    logic        hcs [3];
    logic [15:0] rdata [3];
    logic [15:0] dout [3];
    logic [1:0]  haddr [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        hpi_access_ctrl #(
            .STROBE_CYCLES  (S_TAB[g]),
            .RECOVER_CYCLES (R_TAB[g])
        ) u_dut (
            .Clk          (clk),
            .Reset        (rst),
            .req0         (req0[g]),
            .req1         (req1[g]),
            .we0          (we0[g]),
            .we1          (we1[g]),
            .addr0        (addr0[g]),
            .addr1        (addr1[g]),
            .wdata0       (wdata0[g]),
            .wdata1       (wdata1[g]),
            .ack0         (ack0[g]),
            .ack1         (ack1[g]),
            .rdata        (rdata[g]),
            .busy         (busy[g]),
            .hpi_address  (haddr[g]),
            .hpi_data_out (dout[g]),
            .hpi_data_in  (din[g]),
            .hpi_r        (hr[g]),
            .hpi_w        (hw[g]),
            .hpi_cs       (hcs[g])
        );
    end

    int          checks = 0;
    int          errors = 0;
    int          exp_ptr [3];
    logic [15:0] exp_rdata [3];

    task automatic chk(input string tag, input int d, input int c,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d: got %h want %h", tag, d, c, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input int d, input int c);
        chk("rst_cs", d, c, 16'(hcs[d]), 16'd1);
        chk("rst_r", d, c, 16'(hr[d]), 16'd1);
        chk("rst_w", d, c, 16'(hw[d]), 16'd1);
        chk("rst_ack0", d, c, 16'(ack0[d]), 16'd0);
        chk("rst_ack1", d, c, 16'(ack1[d]), 16'd0);
        chk("rst_busy", d, c, 16'(busy[d]), 16'd0);
        chk("rst_rdata", d, c, rdata[d], 16'h0000);
        chk("rst_addr", d, c, 16'(haddr[d]), 16'd0);
        chk("rst_dout", d, c, dout[d], 16'h0000);
    endtask

    // Called at a negedge while dut d is idle with at least one request raised.
    // Walks the whole access period, comparing against the timeline: grant at the next
    // edge k, cs low k+1..k+S+2, strobe low k+2..k+S+1, ack at k+S+3, idle at k+S+R+3.
    task automatic access(input int d, input bit release_winner, input bit drop_early,
                          input logic [15:0] hold_val);
        int          s;
        int          r;
        int          w;
        bit          wr;
        bit          strobe;
        logic [1:0]  a;
        logic [15:0] wd;
        s = S_TAB[d];
        r = R_TAB[d];
        if (req0[d] && req1[d]) begin
`ifdef HPI_CTRL_RR_EN
            w = exp_ptr[d];
`else
            w = 0;
`endif
        end else begin
            w = req1[d] ? 1 : 0;
        end
        exp_ptr[d] = 1 - w;
        wr = (w == 1) ? we1[d] : we0[d];
        a  = (w == 1) ? addr1[d] : addr0[d];
        wd = (w == 1) ? wdata1[d] : wdata0[d];
        for (int c = 1; c <= s + r + 3; c++) begin
            @(negedge clk);
            din[d] = (c == s + 2) ? hold_val : 16'($urandom);
            if (c == s + 3 && !wr) exp_rdata[d] = hold_val;
            strobe = (c >= 2 && c <= s + 1);
            chk("cs", d, c, 16'(hcs[d]), 16'(!(c <= s + 2)));
            chk("r", d, c, 16'(hr[d]), 16'(!(strobe && !wr)));
            chk("w", d, c, 16'(hw[d]), 16'(!(strobe && wr)));
            chk("ack0", d, c, 16'(ack0[d]), 16'(c == s + 3 && w == 0));
            chk("ack1", d, c, 16'(ack1[d]), 16'(c == s + 3 && w == 1));
            chk("busy", d, c, 16'(busy[d]), 16'(c <= s + r + 2));
            chk("addr", d, c, 16'(haddr[d]), 16'(a));
            chk("dout", d, c, dout[d], wd);
            chk("rdata", d, c, rdata[d], exp_rdata[d]);
            if ((c == 2 && drop_early) || (c == s + 3 && release_winner)) begin
                if (w == 1) req1[d] = 1'b0;
                else req0[d] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            req0[d] = 1'b0;  req1[d] = 1'b0;
            we0[d] = 1'b0;   we1[d] = 1'b0;
            addr0[d] = 2'd0; addr1[d] = 2'd0;
            wdata0[d] = 16'h0; wdata1[d] = 16'h0;
            din[d] = 16'h0;
            exp_ptr[d] = 0;
            exp_rdata[d] = 16'h0;
        end

        // Reset held with a pending write request.
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 2'd2; wdata0[0] = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk_reset_vals(d, i);
        end
        rst = 1'b0;

        // Directed write, read of BEEF, then a write that must leave rdata alone.
        access(0, 1'b1, 1'b0, 16'h0F0F);
        req1[0] = 1'b1; we1[0] = 1'b0; addr1[0] = 2'd0;
        access(0, 1'b1, 1'b0, 16'hBEEF);
        chk("read_beef", 0, 0, rdata[0], 16'hBEEF);
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 2'd1; wdata0[0] = 16'h5555;
        access(0, 1'b1, 1'b0, 16'hAAAA);
        chk("rdata_kept", 0, 0, rdata[0], 16'hBEEF);

        // Contention: both requests held through four back-to-back accesses.
        for (int d = 0; d < 3; d++) begin
            req0[d] = 1'b1; we0[d] = 1'($urandom); addr0[d] = 2'($urandom);
            wdata0[d] = 16'($urandom);
            req1[d] = 1'b1; we1[d] = 1'($urandom); addr1[d] = 2'($urandom);
            wdata1[d] = 16'($urandom);
            for (int n = 0; n < 4; n++) access(d, 1'b0, 1'b0, 16'($urandom));
            req0[d] = 1'b0; req1[d] = 1'b0;
        end

        // Reset arriving during the strobe of a write.
        req0[0] = 1'b1; we0[0] = 1'b1; addr0[0] = 2'd3; wdata0[0] = 16'hC0DE;
        repeat (2) @(negedge clk);
        chk("pre_abort_w", 0, 2, 16'(hw[0]), 16'd0);
        rst = 1'b1;
        #1;
        chk("abort_w", 0, 2, 16'(hw[0]), 16'd1);
        chk("abort_cs", 0, 2, 16'(hcs[0]), 16'd1);
        chk("abort_busy", 0, 2, 16'(busy[0]), 16'd0);
        for (int d = 0; d < 3; d++) begin
            exp_ptr[d] = 0;
            exp_rdata[d] = 16'h0;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_reset_vals(0, 10 + i);
        end
        rst = 1'b0;
        access(0, 1'b1, 1'b0, 16'($urandom));

        // Random traffic: requests raise with fresh fields, winners drop at ack or early.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 25; n++) begin
                if (!req0[d] && ($urandom_range(1, 0) == 1)) begin
                    req0[d] = 1'b1; we0[d] = 1'($urandom); addr0[d] = 2'($urandom);
                    wdata0[d] = 16'($urandom);
                end
                if (!req1[d] && ($urandom_range(1, 0) == 1)) begin
                    req1[d] = 1'b1; we1[d] = 1'($urandom); addr1[d] = 2'($urandom);
                    wdata1[d] = 16'($urandom);
                end
                if (!req0[d] && !req1[d]) begin
                    req1[d] = 1'b1; we1[d] = 1'($urandom); addr1[d] = 2'($urandom);
                    wdata1[d] = 16'($urandom);
                end
                access(d, 1'b1, ($urandom_range(3, 0) == 0), 16'($urandom));
            end
            req0[d] = 1'b0; req1[d] = 1'b0;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
